// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions (g..a codes for hex digits, blank code, debounce default).
// Used by both the encoder side and the monitor/decoder side so the tables cannot diverge.
package seg7_pkg;

    localparam int STABLE_CYCLES_DEF = 4;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] SEG_CODE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] digit;
    } seg_dec_t;

    function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
        return SEG_CODE[digit];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment to hex decoder; zero latency, no flow control.
// legal is set only for the 16 hex codes; blank is set only for the all-off code.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output seg_dec_t   dec
);

    always_comb begin
        dec       = '0;
        dec.blank = (seg == SEG_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_CODE[i]) begin
                dec.legal = 1'b1;
                dec.digit = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_monitor.sv
// Debounced seven-segment monitor checking that displayed digits count up by one mod 16.
// Pulses appear STABLE_CYCLES+2 clocks after a held input change; input is sampled, no backpressure.
module seg7_monitor
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       seg_in,
    output logic [3:0]       digit_out,
    output logic             digit_valid,
    output logic             invalid_pattern,
    output logic             seq_error,
    output logic [ERR_W-1:0] err_count,
    output logic             locked
);

    localparam int CNT_W = 4;

    logic [6:0]       sync1;
    logic [6:0]       sync2;
    logic [6:0]       samp_prev;
    logic [6:0]       last_pat;
    logic [CNT_W-1:0] stab_cnt;

    seg_dec_t         dec;
    logic             stable_hit;
    logic             accept;

    logic [3:0]       digit_nxt;
    logic             valid_nxt;
    logic             invalid_nxt;
    logic             seq_err_nxt;
    logic             locked_nxt;
    logic [ERR_W-1:0] err_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= seg_in;
            sync2 <= sync1;
        end
    end

    // The counter reaching STABLE_CYCLES and the output pulse share one edge,
    // so acceptance is detected one count early on the current sample.
    assign stable_hit = (sync2 == samp_prev) && (stab_cnt == CNT_W'(STABLE_CYCLES - 1));
    assign accept     = stable_hit && (sync2 != last_pat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_prev <= '0;
            stab_cnt  <= '0;
            last_pat  <= '0;
        end else begin
            samp_prev <= sync2;
            if (sync2 != samp_prev) begin
                stab_cnt <= CNT_W'(1);
            end else if (stab_cnt < CNT_W'(STABLE_CYCLES)) begin
                stab_cnt <= stab_cnt + CNT_W'(1);
            end
            if (accept) begin
                last_pat <= sync2;
            end
        end
    end

    seg7_decode u_decode (
        .seg (sync2),
        .dec (dec)
    );

    always_comb begin
        digit_nxt   = digit_out;
        valid_nxt   = 1'b0;
        invalid_nxt = 1'b0;
        seq_err_nxt = 1'b0;
        locked_nxt  = locked;
        err_nxt     = err_count;

        if (accept) begin
            if (dec.legal) begin
                digit_nxt   = dec.digit;
                valid_nxt   = 1'b1;
                seq_err_nxt = locked && (dec.digit != (digit_out + 4'd1));
                locked_nxt  = 1'b1;
            end else if (dec.blank) begin
                locked_nxt  = 1'b0;
            end else begin
                invalid_nxt = 1'b1;
                locked_nxt  = 1'b0;
            end
        end

        // Both error kinds cannot coincide, but a single OR keeps the step at one regardless.
        if ((seq_err_nxt || invalid_nxt) && (err_count != '1)) begin
            err_nxt = err_count + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_out       <= '0;
            digit_valid     <= 1'b0;
            invalid_pattern <= 1'b0;
            seq_error       <= 1'b0;
            err_count       <= '0;
            locked          <= 1'b0;
        end else begin
            digit_out       <= digit_nxt;
            digit_valid     <= valid_nxt;
            invalid_pattern <= invalid_nxt;
            seq_error       <= seq_err_nxt;
            err_count       <= err_nxt;
            locked          <= locked_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_monitor.sv
// Directed bench for seg7_monitor: latency, sequence checking, blank/invalid handling,
// glitch rejection, error-count saturation and reset abort.
module tb_seg7_monitor;

    logic       clk;
    logic       rst;
    logic [6:0] seg_in;
    logic [3:0] digit_out;
    logic       digit_valid;
    logic       invalid_pattern;
    logic       seq_error;
    logic [7:0] err_count;
    logic       locked;

    int checks = 0;
    int errors = 0;

    seg7_monitor #(
        .STABLE_CYCLES (4),
        .ERR_W         (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .seg_in          (seg_in),
        .digit_out       (digit_out),
        .digit_valid     (digit_valid),
        .invalid_pattern (invalid_pattern),
        .seq_error       (seq_error),
        .err_count       (err_count),
        .locked          (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive pat at a falling edge and hold it for 'hold' cycles; the pulse is due
    // exactly at the 6th falling edge (STABLE_CYCLES+2), all other cycles stay quiet.
    task automatic step(input string tag, input logic [6:0] pat, input logic e_dv,
                        input logic e_inv, input logic e_se, input logic [3:0] e_dig,
                        input int hold);
        seg_in = pat;
        for (int k = 1; k <= hold; k++) begin
            @(negedge clk);
            if (k == 6) begin
                check({tag, " digit_valid"}, 32'(digit_valid), 32'(e_dv));
                check({tag, " invalid_pattern"}, 32'(invalid_pattern), 32'(e_inv));
                check({tag, " seq_error"}, 32'(seq_error), 32'(e_se));
                check({tag, " digit_out"}, 32'(digit_out), 32'(e_dig));
            end else begin
                check({tag, " quiet"}, {29'd0, digit_valid, invalid_pattern, seq_error}, 32'd0);
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " digit_out"}, 32'(digit_out), 32'd0);
        check({tag, " pulses"}, {29'd0, digit_valid, invalid_pattern, seq_error}, 32'd0);
        check({tag, " err_count"}, 32'(err_count), 32'd0);
        check({tag, " locked"}, 32'(locked), 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        seg_in = 7'h00;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check_reset_state("idle");

        // Counting 0,1,2
        step("d0", 7'h3F, 1'b1, 1'b0, 1'b0, 4'h0, 10);
        step("d1", 7'h06, 1'b1, 1'b0, 1'b0, 4'h1, 10);
        step("d2", 7'h5B, 1'b1, 1'b0, 1'b0, 4'h2, 10);
        check("count err_count", 32'(err_count), 32'd0);
        check("count locked", 32'(locked), 32'd1);

        // Blank unlocks, then F -> 0 wraps cleanly
        step("blank1", 7'h00, 1'b0, 1'b0, 1'b0, 4'h2, 10);
        check("blank1 locked", 32'(locked), 32'd0);
        step("dF", 7'h71, 1'b1, 1'b0, 1'b0, 4'hF, 10);
        step("wrap0", 7'h3F, 1'b1, 1'b0, 1'b0, 4'h0, 10);
        check("wrap err_count", 32'(err_count), 32'd0);

        // 1 -> 3 skips a digit
        step("d1b", 7'h06, 1'b1, 1'b0, 1'b0, 4'h1, 10);
        step("skip3", 7'h4F, 1'b1, 1'b0, 1'b1, 4'h3, 10);
        check("skip err_count", 32'(err_count), 32'd1);

        // Glitch to 8 for 2 clocks, back to 4: nothing; blank then 8 without error
        step("d4", 7'h66, 1'b1, 1'b0, 1'b0, 4'h4, 10);
        step("glitch", 7'h7F, 1'b0, 1'b0, 1'b0, 4'h4, 2);
        step("repeat4", 7'h66, 1'b0, 1'b0, 1'b0, 4'h4, 10);
        check("glitch digit_out", 32'(digit_out), 32'h4);
        step("blank2", 7'h00, 1'b0, 1'b0, 1'b0, 4'h4, 10);
        check("blank2 locked", 32'(locked), 32'd0);
        step("d8", 7'h7F, 1'b1, 1'b0, 1'b0, 4'h8, 10);
        check("d8 err_count", 32'(err_count), 32'd1);

        // Invalid patterns hold the digit and saturate the error counter
        step("inv55", 7'h55, 1'b0, 1'b1, 1'b0, 4'h8, 10);
        check("inv55 locked", 32'(locked), 32'd0);
        check("inv55 err_count", 32'(err_count), 32'd2);
        for (int i = 0; i < 300; i++) begin
            step("invloop", (i % 2 == 0) ? 7'h2A : 7'h55, 1'b0, 1'b1, 1'b0, 4'h8, 6);
            if (i == 9) check("invloop err_count", 32'(err_count), 32'd12);
        end
        check("sat err_count", 32'(err_count), 32'd255);
        check("sat digit_out", 32'(digit_out), 32'h8);

        // Lock on digit 1, then reset mid-acceptance of 2
        step("pre1", 7'h06, 1'b1, 1'b0, 1'b0, 4'h1, 10);
        check("pre1 locked", 32'(locked), 32'd1);
        seg_in = 7'h5B;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort quiet", {29'd0, digit_valid, invalid_pattern, seq_error}, 32'd0);
        end
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_reset_state("rst_mid");
        end
        rst = 1'b0;
        step("post3", 7'h4F, 1'b1, 1'b0, 1'b0, 4'h3, 10);
        check("post err_count", 32'(err_count), 32'd0);
        check("post locked", 32'(locked), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
